// File: rtl/inner_product_sequencer.sv
// Sequences one inner-product job through an external pipelined multiplier and accumulates results.
// Optional macro INNER_PRODUCT_SEQ_SAT_EN: saturating accumulator plus o_acc_sat flag.
module inner_product_sequencer #(
   parameter int unsigned DATA_W  = 9,
   parameter int unsigned PROD_W  = 8,
   parameter int unsigned ACC_W   = 16,
   parameter int unsigned LEN_W   = 8,
   parameter int unsigned LATENCY = 3
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_start,
   input  logic [LEN_W-1:0]  i_len,
   output logic              o_busy,
   input  logic              i_in_valid,
   output logic              o_in_ready,
   input  logic [DATA_W-1:0] i_in_a,
   input  logic [DATA_W-1:0] i_in_b,
   output logic [DATA_W-1:0] o_dp_inp1,
   output logic [DATA_W-1:0] o_dp_inp2,
   input  logic [PROD_W-1:0] i_dp_outp,
   output logic              o_res_valid,
   input  logic              i_res_ready,
   output logic [ACC_W-1:0]  o_result
`ifdef INNER_PRODUCT_SEQ_SAT_EN
   ,
   output logic              o_acc_sat
`endif
);

   typedef enum logic [1:0] {StIdle, StFeed, StDrain, StDone} state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [LEN_W-1:0]    r_len;
   logic [LEN_W-1:0]    r_issue_cnt;
   logic [LEN_W-1:0]    r_ret_cnt;
   logic [LATENCY:0]    r_tok;
   logic [ACC_W-1:0]    r_acc;
   logic [ACC_W-1:0]    w_acc_next;
   logic [DATA_W-1:0]   r_dp_a;
   logic [DATA_W-1:0]   r_dp_b;
   logic [ACC_W-1:0]    r_result;
   logic                w_xfer;
   logic                w_ret;

   assign w_xfer = (r_state == StFeed) && i_in_valid;
   // Last token stage lines up with the product of the pair issued LATENCY+1 edges earlier
   assign w_ret  = r_tok[LATENCY];

`ifdef INNER_PRODUCT_SEQ_SAT_EN
   logic [ACC_W:0] w_sum;
   logic           r_sat;
   assign w_sum      = {1'b0, r_acc} + (ACC_W + 1)'(i_dp_outp);
   assign w_acc_next = w_sum[ACC_W] ? {ACC_W{1'b1}} : w_sum[ACC_W-1:0];
   assign o_acc_sat  = r_sat;
`else
   assign w_acc_next = r_acc + ACC_W'(i_dp_outp);
`endif

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state <= StIdle;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      unique case (r_state)
         StIdle: begin
            if (i_start) begin
               w_state_next = (i_len == '0) ? StDone : StFeed;
            end
         end
         StFeed: begin
            if (w_xfer && (r_issue_cnt + LEN_W'(1) == r_len)) begin
               w_state_next = StDrain;
            end
         end
         StDrain: begin
            if (r_ret_cnt == r_len) begin
               w_state_next = StDone;
            end
         end
         StDone: begin
            if (i_res_ready) begin
               w_state_next = StIdle;
            end
         end
         default: w_state_next = StIdle;
      endcase
   end

   always_comb begin
      o_busy      = (r_state != StIdle);
      o_in_ready  = (r_state == StFeed);
      o_res_valid = (r_state == StDone);
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_len       <= '0;
         r_issue_cnt <= '0;
         r_ret_cnt   <= '0;
         r_tok       <= '0;
         r_acc       <= '0;
         r_dp_a      <= '0;
         r_dp_b      <= '0;
         r_result    <= '0;
`ifdef INNER_PRODUCT_SEQ_SAT_EN
         r_sat       <= 1'b0;
`endif
      end else begin
         r_tok <= {r_tok[LATENCY-1:0], w_xfer};
         if (w_xfer) begin
            r_dp_a      <= i_in_a;
            r_dp_b      <= i_in_b;
            r_issue_cnt <= r_issue_cnt + LEN_W'(1);
         end
         if (w_ret) begin
            r_acc     <= w_acc_next;
            r_ret_cnt <= r_ret_cnt + LEN_W'(1);
`ifdef INNER_PRODUCT_SEQ_SAT_EN
            if (w_sum[ACC_W]) begin
               r_sat <= 1'b1;
            end
`endif
         end
         if (r_state == StIdle && i_start) begin
            r_len       <= i_len;
            r_issue_cnt <= '0;
            r_ret_cnt   <= '0;
            r_acc       <= '0;
`ifdef INNER_PRODUCT_SEQ_SAT_EN
            r_sat       <= 1'b0;
`endif
            if (i_len == '0) begin
               r_result <= '0;
            end
         end
         // Accumulator already holds the final product by the time the count matches
         if (r_state == StDrain && r_ret_cnt == r_len) begin
            r_result <= r_acc;
         end
      end
   end

   assign o_dp_inp1 = r_dp_a;
   assign o_dp_inp2 = r_dp_b;
   assign o_result  = r_result;

endmodule

// File: tb/tb_inner_product_sequencer.sv
// Scoreboard bench: two sequencers (ACC_W=16 and ACC_W=10) share stimulus, each with its own
// multiplier pipeline model; expected results are queued at issue and checked by monitors.
module tb_inner_product_sequencer;

   localparam int DATA_W = 9;
   localparam int PROD_W = 8;
   localparam int LEN_W  = 8;
   localparam int LAT    = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic              start;
   logic [LEN_W-1:0]  len;
   logic              in_valid;
   logic [DATA_W-1:0] in_a;
   logic [DATA_W-1:0] in_b;
   logic              res_ready;

   logic              busy_a, in_ready_a, res_valid_a;
   logic [DATA_W-1:0] dp1_a, dp2_a;
   logic [PROD_W-1:0] dpo_a;
   logic [15:0]       result_a;
   logic              busy_b, in_ready_b, res_valid_b;
   logic [DATA_W-1:0] dp1_b, dp2_b;
   logic [PROD_W-1:0] dpo_b;
   logic [9:0]        result_b;
`ifdef INNER_PRODUCT_SEQ_SAT_EN
   logic              acc_sat_a, acc_sat_b;
`endif

   logic [PROD_W-1:0] pipe_a [LAT];
   logic [PROD_W-1:0] pipe_b [LAT];
   int                cyc = 0;
   int                n_cmp = 0;
   int                n_err = 0;
   int                acc_edge;
   int                rise;
   logic [15:0]       q_a [$];
   logic [9:0]        q_b [$];

   always #5 clk = ~clk;

   inner_product_sequencer #(
      .DATA_W(DATA_W), .PROD_W(PROD_W), .ACC_W(16), .LEN_W(LEN_W), .LATENCY(LAT)
   ) u_dut_a (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_len(len), .o_busy(busy_a),
      .i_in_valid(in_valid), .o_in_ready(in_ready_a), .i_in_a(in_a), .i_in_b(in_b),
      .o_dp_inp1(dp1_a), .o_dp_inp2(dp2_a), .i_dp_outp(dpo_a), .o_res_valid(res_valid_a),
      .i_res_ready(res_ready), .o_result(result_a)
`ifdef INNER_PRODUCT_SEQ_SAT_EN
      , .o_acc_sat(acc_sat_a)
`endif
   );

   inner_product_sequencer #(
      .DATA_W(DATA_W), .PROD_W(PROD_W), .ACC_W(10), .LEN_W(LEN_W), .LATENCY(LAT)
   ) u_dut_b (
      .i_clk(clk), .i_rst(rst), .i_start(start), .i_len(len), .o_busy(busy_b),
      .i_in_valid(in_valid), .o_in_ready(in_ready_b), .i_in_a(in_a), .i_in_b(in_b),
      .o_dp_inp1(dp1_b), .o_dp_inp2(dp2_b), .i_dp_outp(dpo_b), .o_res_valid(res_valid_b),
      .i_res_ready(res_ready), .o_result(result_b)
`ifdef INNER_PRODUCT_SEQ_SAT_EN
      , .o_acc_sat(acc_sat_b)
`endif
   );

   function automatic logic [7:0] mul8(input logic [8:0] x, input logic [8:0] y);
      logic [17:0] p;
      p = {9'b0, x} * {9'b0, y};
      return p[7:0];
   endfunction

   // Multiplier model: (inp1*inp2) mod 256 through LAT registers, no reset
   initial begin
      for (int i = 0; i < LAT; i++) begin
         pipe_a[i] = '0;
         pipe_b[i] = '0;
      end
   end

   always @(posedge clk) begin
      cyc <= cyc + 1;
      pipe_a[0] <= mul8(dp1_a, dp2_a);
      pipe_b[0] <= mul8(dp1_b, dp2_b);
      for (int i = 1; i < LAT; i++) begin
         pipe_a[i] <= pipe_a[i-1];
         pipe_b[i] <= pipe_b[i-1];
      end
   end
   assign dpo_a = pipe_a[LAT-1];
   assign dpo_b = pipe_b[LAT-1];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic timeout(input string name);
      n_cmp++;
      n_err++;
      $display("FAIL %s: timed out at cycle %0d", name, cyc);
   endtask

   always @(negedge clk) begin
      if (res_valid_a && res_ready) begin
         if (q_a.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL result_a: got unexpected %0d, expected none", result_a);
         end else begin
            check("result_a", 32'(result_a), 32'(q_a.pop_front()));
         end
      end
   end

   always @(negedge clk) begin
      if (res_valid_b && res_ready) begin
         if (q_b.size() == 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL result_b: got unexpected %0d, expected none", result_b);
         end else begin
            check("result_b", 32'(result_b), 32'(q_b.pop_front()));
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_job(input int l);
      len   = LEN_W'(l);
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic send(input int a, input int b, input int gap);
      bit ok;
      repeat (gap) begin
         @(negedge clk);
         check("in_ready_gap", 32'(in_ready_a), 32'd1);
         tick();
      end
      in_a     = DATA_W'(a);
      in_b     = DATA_W'(b);
      in_valid = 1'b1;
      ok       = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (in_ready_a) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (!ok) timeout("in_ready_wait");
      tick();
      acc_edge = cyc;
      in_valid = 1'b0;
   endtask

   task automatic wait_result(output int r);
      r = -1;
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (res_valid_a) begin
            r = cyc;
            return;
         end
      end
      timeout("res_valid_wait");
   endtask

   task automatic wait_idle();
      for (int i = 0; i < 50; i++) begin
         @(negedge clk);
         if (!busy_a && !busy_b) return;
      end
      timeout("idle_wait");
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; len = '0; in_valid = 1'b0;
      in_a = '0; in_b = '0; res_ready = 1'b1;
      repeat (2) tick();
      rst = 1'b0;
      @(negedge clk);
      check("rst_busy", 32'(busy_a), 32'd0);
      check("rst_in_ready", 32'(in_ready_a), 32'd0);
      check("rst_res_valid", 32'(res_valid_a), 32'd0);
      check("rst_result", 32'(result_a), 32'd0);
      check("rst_dp_inp1", 32'(dp1_a), 32'd0);
      check("rst_dp_inp2", 32'(dp2_a), 32'd0);

      // Back-to-back job, 1*2+3*4+5*6 = 44, result 5 edges after last accept
      q_a.push_back(16'd44); q_b.push_back(10'd44);
      start_job(3);
      send(1, 2, 0); send(3, 4, 0); send(5, 6, 0);
      wait_result(rise);
      check("latency_b2b", 32'(rise - acc_edge), 32'd5);
      wait_idle();

      // Same job with 2-cycle gaps between pairs
      q_a.push_back(16'd44); q_b.push_back(10'd44);
      start_job(3);
      send(1, 2, 0); send(3, 4, 2); send(5, 6, 2);
      wait_result(rise);
      check("latency_gap", 32'(rise - acc_edge), 32'd5);
      wait_idle();
      check("gap_busy_low", 32'(busy_a), 32'd0);

      // Zero-length job goes straight to DONE
      q_a.push_back(16'd0); q_b.push_back(10'd0);
      start_job(0);
      @(negedge clk);
      check("len0_res_valid", 32'(res_valid_a), 32'd1);
      check("len0_in_ready", 32'(in_ready_a), 32'd0);
      wait_idle();

      // Consumer stalls 10 cycles, start pulsed meanwhile and on the handshake cycle
      res_ready = 1'b0;
      q_a.push_back(16'd20); q_b.push_back(10'd20);
      start_job(1);
      send(4, 5, 0);
      wait_result(rise);
      for (int i = 0; i < 10; i++) begin
         start = (i == 3);
         len   = 8'd2;
         @(negedge clk);
         check("hold_res_valid", 32'(res_valid_a), 32'd1);
         check("hold_result", 32'(result_a), 32'd20);
         tick();
      end
      start = 1'b1; len = 8'd1; res_ready = 1'b1;
      tick();
      start = 1'b0;
      @(negedge clk);
      check("release_busy", 32'(busy_a), 32'd0);
      check("release_res_valid", 32'(res_valid_a), 32'd0);

      // Reset in the middle of a 4-pair job, then a fresh job must ignore stale products
      start_job(4);
      send(9, 9, 0); send(10, 10, 0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      @(negedge clk);
      check("midrst_busy", 32'(busy_a), 32'd0);
      check("midrst_in_ready", 32'(in_ready_a), 32'd0);
      check("midrst_res_valid", 32'(res_valid_a), 32'd0);
      check("midrst_dp_inp1", 32'(dp1_a), 32'd0);
      q_a.push_back(16'd49); q_b.push_back(10'd49);
      start_job(1);
      send(7, 7, 0);
      wait_result(rise);
      wait_idle();

      // 5 x 255: 1275 at 16 bits; 10 bits wraps to 251 or saturates to 1023
      q_a.push_back(16'd1275);
`ifdef INNER_PRODUCT_SEQ_SAT_EN
      q_b.push_back(10'd1023);
`else
      q_b.push_back(10'd251);
`endif
      start_job(5);
      for (int i = 0; i < 5; i++) send(255, 1, 0);
      wait_result(rise);
`ifdef INNER_PRODUCT_SEQ_SAT_EN
      check("acc_sat_b", 32'(acc_sat_b), 32'd1);
      check("acc_sat_a", 32'(acc_sat_a), 32'd0);
`endif
      wait_idle();

      // Next accepted start clears the saturation flag
      q_a.push_back(16'd0); q_b.push_back(10'd0);
      start_job(0);
      @(negedge clk);
      check("len0_again_valid_b", 32'(res_valid_b), 32'd1);
`ifdef INNER_PRODUCT_SEQ_SAT_EN
      check("acc_sat_cleared", 32'(acc_sat_b), 32'd0);
`endif
      wait_idle();

      repeat (3) tick();
      check("queue_a_drained", 32'(q_a.size()), 32'd0);
      check("queue_b_drained", 32'(q_b.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
